// File: rtl/fpu_addsub_ctrl_pkg.sv
// Shared types and constants for the FPU add/sub controller.
// State encoding, significand-width derivation and iteration-counter width.
package fpu_addsub_ctrl_pkg;

    localparam int unsigned CNT_W = $clog2(54);

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_LOAD_OPS    = 4'd1,
        ST_CLASSIFY    = 4'd2,
        ST_ZERO_CHECK  = 4'd3,
        ST_EXP_DIFF    = 4'd4,
        ST_ALIGN       = 4'd5,
        ST_ADD         = 4'd6,
        ST_NORM_CHECK  = 4'd7,
        ST_NORM_SHIFT  = 4'd8,
        ST_ROUND       = 4'd9,
        ST_ROUND_CHK   = 4'd10,
        ST_LOAD_RESULT = 4'd11,
        ST_ZERO_RESULT = 4'd12,
        ST_READY       = 4'd13
    } state_e;

    function automatic int unsigned sig_w_of(input int unsigned w);
        return (w == 32) ? 24 : 53;
    endfunction

endpackage

// File: rtl/fpu_addsub_ctrl_fsm_if.sv
// Handshake, status and control bundle between the add/sub controller and its
// datapath. master = controller side, slave = datapath / FPU front-end side.
interface fpu_addsub_ctrl_fsm_if;

    logic beg_op_i;
    logic ack_op_i;
    logic zero_flag_i;
    logic add_overflow_i;
    logic norm_needed_i;
    logic round_i;
    logic round_carry_i;
    logic exp_overflow_i;
    logic exp_underflow_i;

    logic load_a_o;
    logic load_b_o;
    logic load_exp_o;
    logic exp_sel_o;
    logic load_shift_o;
    logic load_add_o;
    logic load_norm_o;
    logic shift_dir_o;
    logic load_round_o;
    logic load_result_o;
    logic zero_result_o;
    logic busy_o;
    logic ready_o;
    logic overflow_flag_o;
    logic underflow_flag_o;

    modport master (
        input  beg_op_i, ack_op_i, zero_flag_i, add_overflow_i, norm_needed_i,
               round_i, round_carry_i, exp_overflow_i, exp_underflow_i,
        output load_a_o, load_b_o, load_exp_o, exp_sel_o, load_shift_o,
               load_add_o, load_norm_o, shift_dir_o, load_round_o,
               load_result_o, zero_result_o, busy_o, ready_o,
               overflow_flag_o, underflow_flag_o
    );

    modport slave (
        output beg_op_i, ack_op_i, zero_flag_i, add_overflow_i, norm_needed_i,
               round_i, round_carry_i, exp_overflow_i, exp_underflow_i,
        input  load_a_o, load_b_o, load_exp_o, exp_sel_o, load_shift_o,
               load_add_o, load_norm_o, shift_dir_o, load_round_o,
               load_result_o, zero_result_o, busy_o, ready_o,
               overflow_flag_o, underflow_flag_o
    );

endinterface

// File: rtl/fpu_addsub_ctrl_fsm_norm_iter_counter.sv
// Normalization iteration counter: synchronous clear, increment, saturating at
// SIG_W so a stuck leading-zero flag cannot loop forever.
module norm_iter_counter
    import fpu_addsub_ctrl_pkg::*;
#(
    parameter int unsigned SIG_W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(SIG_W);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/fpu_addsub_ctrl_fsm.sv
// Moore sequencer for the floating-point add/subtract datapath.
// Optional macro RESULT_HOLD_EN: hold READY until ack_op_i instead of one cycle.
module fpu_addsub_ctrl_fsm
    import fpu_addsub_ctrl_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned SIG_W = sig_w_of(W)
) (
    input  logic                  clk,
    input  logic                  rst,
    fpu_addsub_ctrl_fsm_if.master bus
);

    state_e state_q, state_d;
    logic   dir_q, dir_d;
    logic   round_done_q, round_done_d;
    logic   ovf_q, ovf_d;
    logic   unf_q, unf_d;
    logic   at_limit;

    norm_iter_counter #(.SIG_W(SIG_W)) u_norm_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_q == ST_ADD),
        .inc        (state_q == ST_NORM_SHIFT),
        .at_limit_o (at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            round_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            round_done_q <= round_done_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    // Right shifts (adder carry, rounding carry) take priority over left shifts.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        round_done_d = round_done_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        case (state_q)
            ST_IDLE:        if (bus.beg_op_i) state_d = ST_LOAD_OPS;
            ST_LOAD_OPS:    state_d = ST_CLASSIFY;
            ST_CLASSIFY:    state_d = ST_ZERO_CHECK;
            ST_ZERO_CHECK:  state_d = bus.zero_flag_i ? ST_ZERO_RESULT : ST_EXP_DIFF;
            ST_EXP_DIFF:    state_d = ST_ALIGN;
            ST_ALIGN:       state_d = ST_ADD;
            ST_ADD: begin
                round_done_d = 1'b0;
                state_d      = ST_NORM_CHECK;
            end
            ST_NORM_CHECK: begin
                if (bus.add_overflow_i) begin
                    dir_d   = 1'b1;
                    state_d = ST_NORM_SHIFT;
                end else if (bus.norm_needed_i && !at_limit) begin
                    dir_d   = 1'b0;
                    state_d = ST_NORM_SHIFT;
                end else if (round_done_q) begin
                    state_d = ST_LOAD_RESULT;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_NORM_SHIFT:  state_d = ST_NORM_CHECK;
            ST_ROUND:       state_d = bus.round_i ? ST_ROUND_CHK : ST_LOAD_RESULT;
            ST_ROUND_CHK: begin
                round_done_d = 1'b1;
                if (bus.round_carry_i) begin
                    dir_d   = 1'b1;
                    state_d = ST_NORM_SHIFT;
                end else begin
                    state_d = ST_LOAD_RESULT;
                end
            end
            ST_LOAD_RESULT: begin
                ovf_d   = bus.exp_overflow_i;
                unf_d   = bus.exp_underflow_i;
                state_d = ST_READY;
            end
            ST_ZERO_RESULT: begin
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                state_d = ST_READY;
            end
            ST_READY: begin
`ifdef RESULT_HOLD_EN
                if (bus.ack_op_i) state_d = ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            default:        state_d = ST_IDLE;
        endcase
    end

`ifndef RESULT_HOLD_EN
    logic unused_ack;
    assign unused_ack = bus.ack_op_i;
`endif

    always_comb begin
        bus.load_a_o      = 1'b0;
        bus.load_b_o      = 1'b0;
        bus.load_exp_o    = 1'b0;
        bus.exp_sel_o     = 1'b0;
        bus.load_shift_o  = 1'b0;
        bus.load_add_o    = 1'b0;
        bus.load_norm_o   = 1'b0;
        bus.shift_dir_o   = 1'b0;
        bus.load_round_o  = 1'b0;
        bus.load_result_o = 1'b0;
        bus.zero_result_o = 1'b0;
        bus.ready_o       = 1'b0;
        case (state_q)
            ST_LOAD_OPS:    bus.load_a_o = 1'b1;
            ST_CLASSIFY:    bus.load_b_o = 1'b1;
            ST_EXP_DIFF:    bus.load_exp_o = 1'b1;
            ST_ALIGN: begin
                bus.load_shift_o = 1'b1;
                bus.shift_dir_o  = 1'b1;
            end
            ST_ADD:         bus.load_add_o = 1'b1;
            ST_NORM_SHIFT: begin
                bus.load_norm_o = 1'b1;
                bus.load_exp_o  = 1'b1;
                bus.exp_sel_o   = 1'b1;
                bus.shift_dir_o = dir_q;
            end
            ST_ROUND_CHK:   bus.load_round_o = 1'b1;
            ST_LOAD_RESULT: bus.load_result_o = 1'b1;
            ST_ZERO_RESULT: begin
                bus.load_result_o = 1'b1;
                bus.zero_result_o = 1'b1;
            end
            ST_READY:       bus.ready_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy_o           = (state_q != ST_IDLE);
    assign bus.overflow_flag_o  = ovf_q;
    assign bus.underflow_flag_o = unf_q;

endmodule

// File: tb/tb_fpu_addsub_ctrl_fsm.sv
// Self-checking bench for fpu_addsub_ctrl_fsm: vector table of operations with a
// scoreboard of expected latency / pulse counts / flags, plus reset and hold sequences.
module tb_fpu_addsub_ctrl_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fpu_addsub_ctrl_fsm_if bus ();

    fpu_addsub_ctrl_fsm #(.W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    zero;
        int    norm_tgt;
        bit    add_ovf;
        bit    rnd;
        bit    rcar;
        bit    eovf;
        bit    eunf;
        int    lat;
        int    lefts;
        int    rights;
        int    rounds;
        int    expld;
        int    zeros;
        bit    ovf_flag;
        bit    unf_flag;
    } vec_t;

    vec_t vecs[7];
    vec_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] all_outs();
        return {bus.load_a_o, bus.load_b_o, bus.load_exp_o, bus.exp_sel_o,
                bus.load_shift_o, bus.load_add_o, bus.load_norm_o, bus.shift_dir_o,
                bus.load_round_o, bus.load_result_o, bus.zero_result_o, bus.busy_o,
                bus.ready_o, bus.overflow_flag_o, bus.underflow_flag_o, 1'b0};
    endfunction

    task automatic clear_inputs();
        bus.beg_op_i        = 1'b0;
        bus.ack_op_i        = 1'b0;
        bus.zero_flag_i     = 1'b0;
        bus.add_overflow_i  = 1'b0;
        bus.norm_needed_i   = 1'b0;
        bus.round_i         = 1'b0;
        bus.round_carry_i   = 1'b0;
        bus.exp_overflow_i  = 1'b0;
        bus.exp_underflow_i = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input int ack_delay);
        int   cyc = 0;
        int   lefts = 0, rights = 0, rounds = 0, expld = 0, zeros = 0, results = 0;
        int   t_a = 0, t_b = 0, t_e = 0, t_s = 0, t_add = 0, t_r = 0;
        bit   done = 1'b0;
        bit   f_ovf, f_unf;
        vec_t e;
        sb_q.push_back(v);
        @(negedge clk);
        bus.zero_flag_i     = v.zero;
        bus.round_i         = v.rnd;
        bus.round_carry_i   = v.rcar;
        bus.exp_overflow_i  = v.eovf;
        bus.exp_underflow_i = v.eunf;
        bus.add_overflow_i  = v.add_ovf;
        bus.norm_needed_i   = (v.norm_tgt > 0);
        bus.beg_op_i        = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.beg_op_i = 1'b0;
            if (bus.load_a_o && t_a == 0) t_a = cyc;
            if (bus.load_b_o && t_b == 0) t_b = cyc;
            if (bus.load_exp_o && t_e == 0) t_e = cyc;
            if (bus.load_shift_o && t_s == 0) t_s = cyc;
            if (bus.load_add_o && t_add == 0) t_add = cyc;
            if (bus.load_result_o && t_r == 0) t_r = cyc;
            if (bus.load_norm_o) begin
                if (bus.shift_dir_o) rights++;
                else lefts++;
            end
            if (bus.load_round_o) rounds++;
            if (bus.load_exp_o) expld++;
            if (bus.zero_result_o) zeros++;
            if (bus.load_result_o) results++;
            bus.norm_needed_i  = (lefts < v.norm_tgt);
            bus.add_overflow_i = v.add_ovf && (rights == 0);
            if (bus.ready_o) done = 1'b1;
        end
        e = sb_q.pop_front();
        if (!done) begin
            check({e.name, " timeout"}, cyc, e.lat);
            clear_inputs();
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        check({e.name, " latency"}, cyc, e.lat);
        check({e.name, " left_shifts"}, lefts, e.lefts);
        check({e.name, " right_shifts"}, rights, e.rights);
        check({e.name, " round_pulses"}, rounds, e.rounds);
        check({e.name, " exp_loads"}, expld, e.expld);
        check({e.name, " zero_pulses"}, zeros, e.zeros);
        check({e.name, " result_loads"}, results, 1);
        check({e.name, " ovf_flag"}, int'(bus.overflow_flag_o), int'(e.ovf_flag));
        check({e.name, " unf_flag"}, int'(bus.underflow_flag_o), int'(e.unf_flag));
        if (e.zero)
            check({e.name, " order"}, int'(t_a == 1 && t_b == 2 && t_r == 4), 1);
        else
            check({e.name, " order"},
                  int'(t_a == 1 && t_b == 2 && t_e == 4 && t_s == 5 && t_add == 6 && t_r > t_add), 1);
        f_ovf = bus.overflow_flag_o;
        f_unf = bus.underflow_flag_o;
        clear_inputs();
`ifdef RESULT_HOLD_EN
        for (int i = 1; i < ack_delay; i++) begin
            @(negedge clk);
            check({e.name, " ready_held"}, int'(bus.ready_o), 1);
            check({e.name, " flags_held"}, int'({bus.overflow_flag_o, bus.underflow_flag_o}),
                  int'({f_ovf, f_unf}));
        end
        bus.ack_op_i = 1'b1;
        @(negedge clk);
        bus.ack_op_i = 1'b0;
`else
        if (ack_delay > 1) bus.ack_op_i = 1'b0;
        @(negedge clk);
`endif
        check({e.name, " ready_drop"}, int'({bus.ready_o, bus.busy_o}), 0);
    endtask

    initial begin
        //            name        z  nt  ao r  rc eo eu  lat L   R  rn ex zr of uf
        vecs[0] = '{"basic",      0, 0,  0, 0, 0, 0, 0,  10, 0,  0, 0, 1, 0, 0, 0};
        vecs[1] = '{"zero_path",  1, 0,  0, 0, 0, 1, 0,  5,  0,  0, 0, 0, 1, 0, 0};
        vecs[2] = '{"norm3_rcar", 0, 3,  0, 1, 1, 0, 0,  19, 3,  1, 1, 5, 0, 0, 0};
        vecs[3] = '{"norm_stuck", 0, 100,0, 0, 0, 0, 0,  58, 24, 0, 0, 25,0, 0, 0};
        vecs[4] = '{"exp_ovf",    0, 0,  0, 1, 0, 1, 0,  11, 0,  0, 1, 1, 0, 1, 0};
        vecs[5] = '{"add_ovf",    0, 2,  1, 0, 0, 0, 1,  16, 2,  1, 0, 4, 0, 0, 1};
        vecs[6] = '{"zero_clr",   1, 0,  0, 0, 0, 0, 0,  5,  0,  0, 0, 0, 1, 0, 0};

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", int'(all_outs()), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", int'(all_outs()), 0);

        for (int i = 0; i < 7; i++) run_op(vecs[i], 1);

        // Flag set, then reset while in ADD must clear everything.
        run_op(vecs[4], 1);
        begin
            int  k = 0;
            bit  hit = 1'b0;
            @(negedge clk);
            bus.beg_op_i = 1'b1;
            while (!hit && k < 20) begin
                @(negedge clk);
                k++;
                bus.beg_op_i = 1'b0;
                if (bus.load_add_o) hit = 1'b1;
            end
            check("reach_add_cycle", k, 6);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("midop_reset_outputs", int'(all_outs()), 0);
            @(negedge clk);
            check("post_reset_idle", int'(all_outs()), 0);
        end
        run_op(vecs[0], 1);

        run_op(vecs[4], 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
